// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared types, note frequency table and half-period helper for the piano tone generator
package piano_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int NUM_KEYS = 16;

    // Note frequencies in centihertz, C4 up to D6, indexed by key number
    localparam logic [31:0] FREQ_CHZ [NUM_KEYS] = '{
        32'd26163,  32'd29366,  32'd32963,  32'd34923,
        32'd39200,  32'd44000,  32'd49388,  32'd52325,
        32'd58733,  32'd65926,  32'd69846,  32'd78399,
        32'd88000,  32'd98777,  32'd104650, 32'd117466
    };

    // Clock cycles per half wave: clk_hz / (2 * f_hz) = clk_hz * 50 / f_chz, truncated
    function automatic logic [31:0] half_period(input logic [31:0] clk_hz, input int k);
        return (clk_hz * 32'd50) / FREQ_CHZ[k];
    endfunction

endpackage

// File: rtl/tone_divider.sv
// rtl/tone_divider.sv - square-wave divider toggling its output every half period
module tone_divider #(
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             en,
    input  logic             restart,
    input  logic [CNT_W-1:0] half,
    output logic             wave
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wave_q, wave_d;

    // Count up to half-1, then wrap and toggle; restart or disable parks the wave low
    always_comb begin
        cnt_d  = cnt_q;
        wave_d = wave_q;
        if (restart || !en) begin
            cnt_d  = '0;
            wave_d = 1'b0;
        end else if (cnt_q == half - CNT_W'(1)) begin
            cnt_d  = '0;
            wave_d = ~wave_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Divider state registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q  <= '0;
            wave_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
        end
    end

    assign wave = wave_q;

endmodule

// File: rtl/piano_tone_gen.sv
// rtl/piano_tone_gen.sv - last-pressed-wins note selection, release tail and buzzer drive
module piano_tone_gen
    import piano_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 12_000_000,
    parameter int          CNT_W          = 16,
    parameter int unsigned RELEASE_CYCLES = 1_200_000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [15:0] key_out,
    input  logic [15:0] key_pulse,
    output logic        beep,
    output logic [3:0]  note_idx,
    output logic        playing
);

    localparam int REL_W = $clog2(RELEASE_CYCLES + 1);

    logic [CNT_W-1:0] half_tab [NUM_KEYS];
    logic [CNT_W-1:0] half_sel;

    state_t           state_q, state_d;
    logic [3:0]       note_q, note_d;
    logic [REL_W-1:0] rel_q, rel_d;
    logic             playing_q, playing_d;
    logic [3:0]       sel;
    logic             any_pulse;
    logic             div_en;
    logic             div_restart;

    if (RELEASE_CYCLES < 1) begin : g_rel_err
        $error("RELEASE_CYCLES must be at least 1");
    end

    // Constant half-period table; a value that does not fit the counter is rejected here
    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_half
        localparam logic [31:0] HALF_FULL = half_period(CLK_HZ, k);
        if ({32'd0, HALF_FULL} >= (64'd1 << CNT_W)) begin : g_width_err
            $error("half period does not fit in CNT_W bits");
        end
        assign half_tab[k] = HALF_FULL[CNT_W-1:0];
    end

    assign half_sel = half_tab[note_q];

    // Lowest set pulse bit wins when several keys arrive in the same cycle
    always_comb begin
        sel = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (key_pulse[i]) begin
                sel = 4'(i);
            end
        end
    end

    assign any_pulse = |key_pulse;

    // Next state: a pulse always (re)starts a note; otherwise track release and tail expiry
    always_comb begin
        state_d     = state_q;
        note_d      = note_q;
        rel_d       = rel_q;
        div_restart = 1'b0;
        if (any_pulse) begin
            state_d     = PLAY;
            note_d      = sel;
            rel_d       = '0;
            div_restart = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    rel_d = '0;
                end
                PLAY: begin
                    if (key_out[note_q]) begin
                        state_d = RELEASE;
                        rel_d   = '0;
                    end
                end
                RELEASE: begin
                    if (rel_q == REL_W'(RELEASE_CYCLES - 1)) begin
                        state_d = IDLE;
                        rel_d   = '0;
                    end else begin
                        rel_d = rel_q + REL_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    rel_d   = '0;
                end
            endcase
        end
        playing_d = (state_d != IDLE);
        div_en    = (state_d != IDLE);
    end

    // FSM, note and release-counter registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            note_q    <= 4'd0;
            rel_q     <= '0;
            playing_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            note_q    <= note_d;
            rel_q     <= rel_d;
            playing_q <= playing_d;
        end
    end

    tone_divider #(
        .CNT_W (CNT_W)
    ) u_div (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .en       (div_en),
        .restart  (div_restart),
        .half     (half_sel),
        .wave     (beep)
    );

    assign note_idx = note_q;
    assign playing  = playing_q;

endmodule

// File: tb/tb_piano_tone_gen.sv
// tb/tb_piano_tone_gen.sv - self-checking bench for piano_tone_gen against a behavioural note model
module tb_piano_tone_gen;

    localparam int unsigned REL = 100;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [15:0] key_out;
    logic [15:0] key_pulse;
    logic        beep;
    logic [3:0]  note_idx;
    logic        playing;

    piano_tone_gen #(
        .CLK_HZ         (12_000_000),
        .CNT_W          (16),
        .RELEASE_CYCLES (REL)
    ) dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .key_out   (key_out),
        .key_pulse (key_pulse),
        .beep      (beep),
        .note_idx  (note_idx),
        .playing   (playing)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Behavioural model: a note is a start time plus an optional release time
    int unsigned freq [16] = '{26163, 29366, 32963, 34923, 39200, 44000, 49388, 52325,
                               58733, 65926, 69846, 78399, 88000, 98777, 104650, 117466};
    longint m_half [16];
    bit     m_active;
    int     m_note;
    longint m_t;
    bit     m_rel;
    longint m_cyc;
    longint m_rs;
    bit     model_on = 1'b0;

    initial begin
        for (int k = 0; k < 16; k++) m_half[k] = (64'd12_000_000 * 50) / freq[k];
    end

    function automatic int lowest(input logic [15:0] p);
        for (int i = 0; i < 16; i++) if (p[i]) return i;
        return 0;
    endfunction

    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            m_active = 0; m_note = 0; m_t = 0; m_rel = 0; m_cyc = 0; m_rs = 0;
        end else begin
            m_cyc++;
            if (key_pulse != 16'h0) begin
                m_active = 1; m_note = lowest(key_pulse); m_t = 0; m_rel = 0;
            end else if (m_active) begin
                m_t++;
                if (m_rel) begin
                    if (m_cyc - m_rs == REL) m_active = 0;
                end else if (key_out[m_note]) begin
                    m_rel = 1; m_rs = m_cyc;
                end
            end
        end
    end

    // Every cycle, compare outputs with the model
    always @(negedge clk_in) begin
        #1;
        if (model_on) begin
            check("cyc_playing", playing, m_active);
            check("cyc_note", note_idx, m_note);
            check("cyc_beep", beep, m_active ? ((m_t / m_half[m_note]) % 2) : 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic press(input logic [15:0] p);
        key_out   = key_out & ~p;
        key_pulse = p;
        @(negedge clk_in);
        key_pulse = '0;
    endtask

    task automatic wait_lvl(input logic lvl, input int budget, output int n);
        n = 0;
        while (beep !== lvl && n < budget) begin
            @(negedge clk_in);
            n++;
        end
    endtask

    int n, hp, hb, drops;
    int r;
    logic [15:0] p;

    initial begin
        rst_n_in  = 1'b0;
        key_out   = '1;
        key_pulse = '0;
        @(negedge clk_in);
        model_on = 1'b1;
        tick(2);
        rst_n_in = 1'b1;
        tick(2);
        check("reset_beep", beep, 0);
        check("reset_note", note_idx, 0);
        check("reset_playing", playing, 0);

        // single press on key 5
        press(16'h0020);
        check("p5_note", note_idx, 5);
        check("p5_playing", playing, 1);
        wait_lvl(1'b1, 30000, n);
        check("p5_first_rise", n, 13636);
        wait_lvl(1'b0, 30000, n);
        check("p5_high_time", n, 13636);

        // simultaneous pulses: lowest index wins
        key_out = '1;
        press(16'h0A00);
        check("sim_note", note_idx, 9);
        wait_lvl(1'b1, 20000, n);
        check("sim_half", n, 9101);

        // note change mid-period, then old key release is ignored
        key_out = '1;
        press(16'h0001);
        tick(3000);
        press(16'h8000);
        key_out[0] = 1'b1;
        check("chg_beep_cleared", beep, 0);
        wait_lvl(1'b1, 20000, n);
        check("chg_half", n, 5107);
        check("chg_note", note_idx, 15);
        check("chg_playing", playing, 1);

        // re-press during the release tail
        drops = 0;
        key_out[15] = 1'b1;
        repeat (30) begin
            @(negedge clk_in);
            if (!playing) drops++;
        end
        press(16'h0008);
        check("rp_note", note_idx, 3);
        repeat (20) begin
            @(negedge clk_in);
            if (!playing) drops++;
        end
        check("rp_no_drop", drops, 0);

        // release tail while beep is high
        key_out = '1;
        press(16'h8000);
        wait_lvl(1'b1, 20000, n);
        tick(10);
        key_out[15] = 1'b1;
        hp = 0; hb = 0;
        repeat (300) begin
            @(negedge clk_in);
            if (playing) hp++;
            if (beep) hb++;
        end
        check("tail_playing_len", hp, 100);
        check("tail_beep_len", hb, 100);
        check("tail_end_beep", beep, 0);
        check("tail_end_note", note_idx, 15);

        // reset in the middle of a note
        key_out = '1;
        press(16'h8000);
        wait_lvl(1'b1, 20000, n);
        tick(5);
        rst_n_in = 1'b0;
        #1;
        check("rst_beep", beep, 0);
        check("rst_note", note_idx, 0);
        check("rst_playing", playing, 0);
        tick(3);
        rst_n_in = 1'b1;
        hp = 0;
        repeat (50) begin
            @(negedge clk_in);
            if (playing) hp++;
        end
        check("post_rst_idle", hp, 0);

        // randomized pulses and key releases against the model
        key_out = '1;
        repeat (6000) begin
            @(negedge clk_in);
            key_pulse = '0;
            r = $urandom_range(0, 99);
            if (r < 1) begin
                p = 16'h1 << $urandom_range(0, 15);
                if ($urandom_range(0, 3) == 0) p = p | (16'h1 << $urandom_range(0, 15));
                key_out   = key_out & ~p;
                key_pulse = p;
            end else if (r < 4) begin
                key_out[$urandom_range(0, 15)] = 1'b1;
            end else if (r == 4) begin
                key_out[$urandom_range(0, 15)] = 1'b0;
            end
        end
        @(negedge clk_in);
        key_pulse = '0;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/piano_tone_gen.md
# piano_tone_gen

Downstream consumer of the 4x4 matrix-keyboard scanner. Takes the scanner's debounced active-low key levels and one-cycle press pulses, and selects one note with last-pressed-wins priority. Drives a square wave at that note's pitch on a single buzzer pin, with a fixed release tail after the key is let go. It is the only sound source in the piano design.

## Interface
- `CLK_HZ`, default 12_000_000: input clock frequency, in Hz.
- `CNT_W`, default 16: width of the half-period counter. It must hold the largest half-period, which is 22933 at 12 MHz.
- `RELEASE_CYCLES`, default 1_200_000: length of the release tail, 100 ms at 12 MHz. Must be ≥1.
- `clk_in`, input, 1: system clock.
- `rst_n_in`, input, 1: reset, asynchronous, active-low. The block has one clock, `clk_in`; reset is asynchronous and active-low.
- `key_out`, input, 16: key levels from the scanner. 0 means pressed. Updated at the scan rate.
- `key_pulse`, input, 16: one-`clk_in`-cycle high per newly pressed key.
- `beep`, output, 1: square-wave tone, registered.
- `note_idx`, output, 4: index of the key currently sounding, registered.
- `playing`, output, 1: high in PLAY and RELEASE, registered.

## Operation
- **Note map.** Keys 0..15 are C4 D4 E4 F4 G4 A4 B4 C5 D5 E5 F5 G5 A5 B5 C6 D6.
- **Frequency constants.** Each frequency is stored in centihertz: 26163 29366 32963 34923 39200 44000 49388 52325 58733 65926 69846 78399 88000 98777 104650 117466.
- **Half-period.** half[k] = CLK_HZ*50 / FREQ_CHZ[k]. Compute it with 32-bit unsigned integer division, truncated, at elaboration. Examples: half[0]=22933, half[5]=13636.
- **Press selection.** If any bit of `key_pulse` is set, the lowest set index is the new note. Other simultaneous pulses are ignored.
- **States.** The FSM has three states: IDLE, PLAY and RELEASE. Reset enters IDLE.
- **IDLE.**
  - Counter is held at 0, `beep`=0, `playing`=0.
  - A pulse moves to PLAY: `note_idx`←sel, counter←0, `beep`←0.
- **PLAY.**
  - Divider runs. When counter==half[note_idx]-1: counter←0 and `beep` toggles. Otherwise counter increments.
  - A pulse takes priority over everything else in PLAY. It loads the new note (the same key counts as new), with counter←0 and `beep`←0, and stays in PLAY.
  - Otherwise, if `key_out[note_idx]`==1 (released), go to RELEASE with release counter←0. The divider keeps running.
- **RELEASE.**
  - Divider keeps running on the same note. The release counter increments.
  - A pulse returns to PLAY and loads the note as in PLAY.
  - When the release counter reaches RELEASE_CYCLES-1, go to IDLE: `beep`←0, counter←0, `note_idx` holds.
  - Re-pressing the held note's key without a pulse (`key_out` back to 0) does not restart the note. Only pulses start notes.
- **Reset mid-operation.** Reset immediately forces IDLE, `beep`=0, `note_idx`=0, `playing`=0, and both counters to 0.

## Timing
- **Reset values.** `beep`=0, `note_idx`=0, `playing`=0.
- **Note start.** A pulse sampled at edge N gives `playing`=1, `note_idx` valid and counter=0 after edge N. `beep` first rises at edge N+half[k]. The period is 2*half[k] cycles, duty 50%.
- **Release detect.** This takes one cycle. Tail length from the RELEASE entry edge to the IDLE entry edge is RELEASE_CYCLES cycles.
- **Input timing.** There is no input registering beyond the FSM itself. `key_pulse` is already one cycle wide and synchronous to `clk_in`.
- **Counter width.** Counter compare uses CNT_W bits. Any half[k] ≥ 2^CNT_W is an elaboration error.

## Structure
- **`piano_pkg`.**
  - The state enum: IDLE, PLAY, RELEASE.
  - The FREQ_CHZ[16] constant array.
  - A constant function `half_period(clk_hz, k)`.
- **`tone_divider`.** One natural sub-module. Inputs: `clk_in`, `rst_n_in`, `en`, `restart`, `half[CNT_W-1:0]`. Output: registered `wave`.
- **`piano_tone_gen`.** Contains the FSM, the priority encoder, the release counter and the half-period lookup mux.

## Test plan
- **Single press.** Apply pulse on bit 5 and hold `key_out[5]`=0 → `note_idx`=5, `playing`=1 one cycle later. `beep` rises 13636 cycles after the pulse edge, with period 27272.
- **Simultaneous press.** Apply `key_pulse`=16'h0A00 → `note_idx`=9, and half-period=9101 is measured.
- **Release tail.** Set RELEASE_CYCLES=100. Hold key 0, then drive `key_out[0]`←1 → `beep` keeps toggling for exactly 100 cycles after RELEASE entry. Then `playing`=0 and `beep`=0 and stay low.
- **Note change.** While key 0 plays, pulse bit 15 in mid-period → `beep`=0 and counter restarts, giving half-period 5107. Releasing key 0 has no effect.
- **Re-press in RELEASE.** Pulse bit 3 during RELEASE → PLAY with `note_idx`=3, and `playing` never drops.
- **Reset mid-note.** Assert `rst_n_in`=0 mid-PLAY for 3 cycles → all outputs 0 within the assert cycle. After deassert, the block stays IDLE until the next pulse.
